acc_cpu_param: RTL and testbench
================================

# acc_cpu_param

Parametrised successor to the team's 8-bit accumulator CPU: a two-cycle fetch/execute accumulator machine with configurable data and address widths. It has a Harvard split (instruction RAM loadable while halted, data RAM written only by STORE), Z/C flags, immediate load, I/O opcodes, conditional branches and an explicit halt/start handshake. It sits as the compute core between the program loader and the board I/O.

## Interface
- DATA_W, 8, accumulator / data RAM word width (≥ 2)
- ADDR_W, 5, operand/address field width; each RAM depth = 2^ADDR_W; instruction width = ADDR_W+4
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  leave HALT, begin execution at address 0
- prog_we  in  1  instruction RAM write strobe
- prog_addr  in  ADDR_W  instruction RAM write address
- prog_data  in  ADDR_W+4  instruction word {opcode[3:0], operand a}
- data_in  in  DATA_W  external input sampled by IN
- acc_out  out  DATA_W  accumulator
- pc_out  out  ADDR_W  program counter
- out_data  out  DATA_W  last value written by OUT
- out_valid  out  1  one-cycle pulse when out_data updates
- halted  out  1  core is in HALT
- zero_flag  out  1  Z flag
- carry_flag  out  1  C flag

## Operation
- States: HALT, FETCH, EXEC.
  - HALT: halted=1. start → pc<=0, go to FETCH. prog_we writes IMEM[prog_addr]<=prog_data.
  - FETCH: ir<=IMEM[pc]; pc<=pc+1 mod 2^ADDR_W; go to EXEC.
  - EXEC: execute ir; go to FETCH, or to HALT for opcode F.
- Opcodes (a = ir[ADDR_W-1:0], M = data RAM):
  - 0 ADD: acc<=acc+M[a]; C = carry out.
  - 1 SUB: acc<=acc−M[a]; C = borrow.
  - 2 LOAD: acc<=M[a].
  - 3 STORE: M[a]<=acc.
  - 4 AND, 5 OR, 6 XOR: acc<=acc op M[a].
  - 7 LDI: acc<=a, zero-extended, or truncated to the low DATA_W bits.
  - 8 IN: acc<=data_in.
  - 9 OUT: out_data<=acc; out_valid=1 for 1 cycle.
  - A JMP: pc<=a.
  - B JZ: if Z, pc<=a.
  - C JC: if C, pc<=a.
  - D, E NOP.
  - F HALT.
- Z <= (new acc == 0) on every acc-writing opcode (0,1,2,4,5,6,7,8); otherwise Z holds.
- C changes only on ADD/SUB.
- Arithmetic is modulo 2^DATA_W; the carry is bit DATA_W of the (DATA_W+1)-bit result.
- A taken branch overrides the incremented pc. A not-taken branch behaves as a NOP.
- Reset values:
  - acc_out=0, pc_out=0, out_data=0, out_valid=0, flags=0, ir=0.
  - State=HALT, so halted=1.
  - RAMs are not reset; data RAM contents are undefined until STOREd.

## Timing
- Every instruction takes 2 cycles. With start sampled at edge k, instruction n executes at edge k+2n+2.
- HALT as the nth instruction (n counted from 0) makes halted=1 after edge k+2n+2.
- out_valid is high exactly the cycle after the OUT EXEC edge.
- STORE followed by LOAD of the same address returns the stored value. The write completes at the EXEC edge, before the next FETCH.
- pc wraps from 2^ADDR_W−1 to 0 without error.
- start or prog_we outside HALT: ignored, with no side effects.
- start and prog_we in the same HALT cycle: the write happens and start is taken. The first FETCH sees the written word.
- reset_n low at any point (including mid-EXEC STORE) forces reset values immediately.
  - An EXEC edge coincident with reset has no RAM write.
  - Release is synchronous to the next edge. The core stays in HALT until start.

## Configuration
- ACC_CPU_BRANCH_EN defined:
  - JMP/JZ/JC behave as above.
- ACC_CPU_BRANCH_EN undefined:
  - Opcodes A–C are NOPs; pc always increments.
  - Branch-condition logic is removed.

## Test plan
- Reset: hold reset_n=0 for 3 cycles, release → halted=1, acc_out=0, pc_out=0, out_valid=0, flags=0; no activity without start.
- Straight-line: load LDI 5, STORE 3, LDI 7, ADD 3, OUT, HALT; pulse start → out_data=12 with out_valid one cycle high; halted=1 exactly 12 cycles after start.
- Flags: LDI 0, STORE 0, LDI 1, STORE 1, LDI 0, SUB 1 → acc=255, C=1, Z=0; then ADD 1 → acc=0, C=1, Z=1; then AND 0 → C stays 1.
- Branch (macro on): countdown LDI 3, STORE 2, LDI 1, STORE 1, LOAD 2, SUB 1, STORE 2, JZ 9, JMP 4, HALT → halts with M[2]=0. With macro off, the same program runs through without looping; JZ/JMP act as NOPs.
- Wrap/ignore: 32 NOPs → pc_out goes 31→0 and execution continues. prog_we and start pulsed while running → IMEM unchanged, pc sequence undisturbed.
- Reset mid-op: assert reset_n=0 on the EXEC edge of STORE 4 (acc=9) → M[4] not written. After restart, LOAD 4 returns the prior value.

Source files
------------

// File: rtl/acc_cpu_param.sv
// ---------------------------------------------------------------------------
// acc_cpu_param
//   Two-cycle fetch/execute accumulator core with configurable data and
//   address widths. Harvard split: the instruction RAM is loaded through the
//   prog_* port while halted, and the data RAM is written only by STORE.
//
// Parameters
//   DATA_W  accumulator / data RAM word width (>= 2)
//   ADDR_W  operand field width; both RAMs hold 2^ADDR_W words and an
//           instruction is ADDR_W+4 bits: {opcode[3:0], operand}
//
// Ports
//   clk, reset_n   rising-edge clock, asynchronous active-low reset
//   start          leave HALT and begin executing at address 0
//   prog_we        instruction RAM write strobe (honoured only in HALT)
//   prog_addr      instruction RAM write address
//   prog_data      instruction word
//   data_in        external input sampled by IN
//   acc_out        accumulator
//   pc_out         program counter
//   out_data       last value written by OUT
//   out_valid      one-cycle pulse when out_data updates
//   halted         core is in HALT
//   zero_flag      Z flag
//   carry_flag     C flag
//
// Configuration
//   ACC_CPU_BRANCH_EN  defined: JMP/JZ/JC load the pc.
//                      undefined: opcodes A-C are NOPs and the branch
//                      condition logic is not built.
// ---------------------------------------------------------------------------
module acc_cpu_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [ADDR_W+3:0]   prog_data,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   acc_out,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    output logic                halted,
    output logic                zero_flag,
    output logic                carry_flag
);

    localparam int unsigned INSTR_W = ADDR_W + 4;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_LDI   = 4'h7;
    localparam logic [3:0] OP_IN    = 4'h8;
    localparam logic [3:0] OP_OUT   = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_JC    = 4'hC;
    localparam logic [3:0] OP_NOP_D = 4'hD;
    localparam logic [3:0] OP_NOP_E = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    // Architectural state
    state_t                 r_state;
    logic [ADDR_W-1:0]      r_pc;
    logic [INSTR_W-1:0]     r_ir;
    logic [DATA_W-1:0]      r_acc;
    logic                   r_z;
    logic                   r_c;
    logic [DATA_W-1:0]      r_out_data;
    logic                   r_out_valid;
    logic                   r_halted;
    logic [INSTR_W-1:0]     r_imem [DEPTH];
    logic [DATA_W-1:0]      r_dmem [DEPTH];

    // Decode / datapath nets
    state_t                 w_state_nxt;
    logic [3:0]             w_op;
    logic [ADDR_W-1:0]      w_a;
    logic [DATA_W-1:0]      w_mem;
    logic [DATA_W:0]        w_sum;
    logic [DATA_W:0]        w_diff;
    logic                   w_imem_we;
    logic                   w_pc_clr;
    logic                   w_fetch;
    logic                   w_branch;
    logic                   w_acc_we;
    logic [DATA_W-1:0]      w_acc_nxt;
    logic                   w_c_we;
    logic                   w_c_nxt;
    logic                   w_dmem_we;
    logic                   w_out_fire;

    assign w_op   = r_ir[INSTR_W-1:ADDR_W];
    assign w_a    = r_ir[ADDR_W-1:0];
    assign w_mem  = r_dmem[w_a];

    // Extended-width arithmetic: bit DATA_W is carry-out for ADD and borrow for SUB
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_mem};
    assign w_diff = {1'b0, r_acc} - {1'b0, w_mem};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HALT: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (w_op == OP_HALT) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_HALT;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        w_imem_we  = 1'b0;
        w_pc_clr   = 1'b0;
        w_fetch    = 1'b0;
        w_branch   = 1'b0;
        w_acc_we   = 1'b0;
        w_acc_nxt  = r_acc;
        w_c_we     = 1'b0;
        w_c_nxt    = r_c;
        w_dmem_we  = 1'b0;
        w_out_fire = 1'b0;
        case (r_state)
            S_HALT: begin
                // A write and a start in the same cycle are both honoured
                w_imem_we = prog_we;
                w_pc_clr  = start;
            end
            S_FETCH: begin
                w_fetch = 1'b1;
            end
            S_EXEC: begin
                case (w_op)
                    OP_ADD: begin
                        w_acc_we  = 1'b1;
                        w_acc_nxt = w_sum[DATA_W-1:0];
                        w_c_we    = 1'b1;
                        w_c_nxt   = w_sum[DATA_W];
                    end
                    OP_SUB: begin
                        w_acc_we  = 1'b1;
                        w_acc_nxt = w_diff[DATA_W-1:0];
                        w_c_we    = 1'b1;
                        w_c_nxt   = w_diff[DATA_W];
                    end
                    OP_LOAD: begin
                        w_acc_we  = 1'b1;
                        w_acc_nxt = w_mem;
                    end
                    OP_STORE: begin
                        w_dmem_we = 1'b1;
                    end
                    OP_AND: begin
                        w_acc_we  = 1'b1;
                        w_acc_nxt = r_acc & w_mem;
                    end
                    OP_OR: begin
                        w_acc_we  = 1'b1;
                        w_acc_nxt = r_acc | w_mem;
                    end
                    OP_XOR: begin
                        w_acc_we  = 1'b1;
                        w_acc_nxt = r_acc ^ w_mem;
                    end
                    OP_LDI: begin
                        // Zero-extends or truncates the operand to DATA_W
                        w_acc_we  = 1'b1;
                        w_acc_nxt = DATA_W'(w_a);
                    end
                    OP_IN: begin
                        w_acc_we  = 1'b1;
                        w_acc_nxt = data_in;
                    end
                    OP_OUT: begin
                        w_out_fire = 1'b1;
                    end
`ifdef ACC_CPU_BRANCH_EN
                    OP_JMP: begin
                        w_branch = 1'b1;
                    end
                    OP_JZ: begin
                        w_branch = r_z;
                    end
                    OP_JC: begin
                        w_branch = r_c;
                    end
`else
                    OP_JMP, OP_JZ, OP_JC: begin
                        w_branch = 1'b0;
                    end
`endif
                    OP_NOP_D, OP_NOP_E, OP_HALT: begin
                        w_branch = 1'b0;
                    end
                    default: begin
                        w_branch = 1'b0;
                    end
                endcase
            end
            default: begin
                w_branch = 1'b0;
            end
        endcase
    end

    // Datapath and RAM writes; RAM writes sit under the reset branch so an
    // edge coincident with reset never commits a write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_acc       <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b1;
        end else begin
            r_out_valid <= w_out_fire;
            r_halted    <= (w_state_nxt == S_HALT);

            // Only one of these can be active in a given state
            if (w_pc_clr) begin
                r_pc <= '0;
            end else if (w_fetch) begin
                r_pc <= r_pc + ADDR_W'(1);
            end else if (w_branch) begin
                r_pc <= w_a;
            end

            if (w_fetch) begin
                r_ir <= r_imem[r_pc];
            end

            if (w_acc_we) begin
                r_acc <= w_acc_nxt;
                r_z   <= (w_acc_nxt == '0);
            end

            if (w_c_we) begin
                r_c <= w_c_nxt;
            end

            if (w_out_fire) begin
                r_out_data <= r_acc;
            end

            if (w_imem_we) begin
                r_imem[prog_addr] <= prog_data;
            end

            if (w_dmem_we) begin
                r_dmem[w_a] <= r_acc;
            end
        end
    end

    assign acc_out    = r_acc;
    assign pc_out     = r_pc;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign halted     = r_halted;
    assign zero_flag  = r_z;
    assign carry_flag = r_c;

endmodule

// File: tb/tb_acc_cpu_param.sv
// ---------------------------------------------------------------------------
// tb_acc_cpu_param
//   Directed vector table with hand-derived results, multi-cycle sequences
//   for pc wrap / ignored strobes / reset during STORE, and random programs
//   checked against an instruction-level reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acc_cpu_param;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int IW    = AW + 4;
    localparam int DEPTH = 1 << AW;
    localparam int MASK  = (1 << DW) - 1;
`ifdef ACC_CPU_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [DW-1:0] data_in;
    logic [DW-1:0] acc_out;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          halted;
    logic          zero_flag;
    logic          carry_flag;

    acc_cpu_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .data_in    (data_in),
        .acc_out    (acc_out),
        .pc_out     (pc_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .halted     (halted),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [IW-1:0] rom [$];
    int            dut_outs [$];

    // Reference model state (instruction-level)
    logic [IW-1:0] m_imem [DEPTH];
    int            m_dmem [DEPTH];
    int            m_acc, m_z, m_c, m_out, m_pc, m_instr;
    int            m_outs [$];

    typedef struct {
        int p0;
        int len;
        int din;
        int acc;
        int z;
        int c;
        int pc;
        int cyc;
        int nout;
        int odata;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] enc(input int op, input int a);
        return {4'(op), AW'(a)};
    endfunction

    task automatic model_reset();
        m_acc = 0; m_z = 0; m_c = 0; m_out = 0;
    endtask

    // Executes the model's program memory from address 0 until HALT
    task automatic model_run(input int din);
        int pc, n, op, a, t;
        bit done;
        pc = 0; n = 0; done = 1'b0;
        m_outs.delete();
        while (!done && n < 1000) begin
            op = int'(m_imem[pc][IW-1:AW]);
            a  = int'(m_imem[pc][AW-1:0]);
            pc = (pc + 1) % DEPTH;
            n++;
            case (op)
                0: begin t = m_acc + m_dmem[a]; m_c = int'(t > MASK); m_acc = t & MASK; m_z = int'(m_acc == 0); end
                1: begin t = m_acc - m_dmem[a]; m_c = int'(t < 0);    m_acc = t & MASK; m_z = int'(m_acc == 0); end
                2: begin m_acc = m_dmem[a];            m_z = int'(m_acc == 0); end
                3: m_dmem[a] = m_acc;
                4: begin m_acc = m_acc & m_dmem[a];    m_z = int'(m_acc == 0); end
                5: begin m_acc = m_acc | m_dmem[a];    m_z = int'(m_acc == 0); end
                6: begin m_acc = m_acc ^ m_dmem[a];    m_z = int'(m_acc == 0); end
                7: begin m_acc = a & MASK;             m_z = int'(m_acc == 0); end
                8: begin m_acc = din & MASK;           m_z = int'(m_acc == 0); end
                9: begin m_out = m_acc; m_outs.push_back(m_acc); end
                10: if (BR_EN) pc = a;
                11: if (BR_EN && m_z != 0) pc = a;
                12: if (BR_EN && m_c != 0) pc = a;
                15: done = 1'b1;
                default: ;
            endcase
        end
        m_pc    = pc;
        m_instr = n;
    endtask

    task automatic load_prog(input int p0, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = AW'(i);
            prog_data = rom[p0 + i];
            m_imem[i] = rom[p0 + i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Pulses start and counts edges (start edge = 0) until halted rises
    task automatic run_dut(input int din, output int edges);
        dut_outs.delete();
        @(negedge clk);
        data_in = DW'(din);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        while (halted !== 1'b1 && edges < 300) begin
            if (out_valid === 1'b1) dut_outs.push_back(int'(out_data));
            @(negedge clk);
            edges++;
        end
        chk("run_halts_in_budget", int'(halted === 1'b1), 1);
    endtask

    task automatic run_vs_model(input string nm, input int din);
        int edges;
        model_run(din);
        run_dut(din, edges);
        chk({nm, "_acc"},    int'(acc_out),    m_acc);
        chk({nm, "_z"},      int'(zero_flag),  m_z);
        chk({nm, "_c"},      int'(carry_flag), m_c);
        chk({nm, "_pc"},     int'(pc_out),     m_pc);
        chk({nm, "_cycles"}, edges,            2 * m_instr);
        chk({nm, "_odata"},  int'(out_data),   m_out);
        chk({nm, "_nout"},   dut_outs.size(),  m_outs.size());
        if (dut_outs.size() == m_outs.size()) begin
            for (int k = 0; k < m_outs.size(); k++) begin
                chk($sformatf("%s_out%0d", nm, k), dut_outs[k], m_outs[k]);
            end
        end
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_halted"}, int'(halted),     1);
        chk({nm, "_acc"},    int'(acc_out),    0);
        chk({nm, "_pc"},     int'(pc_out),     0);
        chk({nm, "_ovalid"}, int'(out_valid),  0);
        chk({nm, "_odata"},  int'(out_data),   0);
        chk({nm, "_z"},      int'(zero_flag),  0);
        chk({nm, "_c"},      int'(carry_flag), 0);
    endtask

    initial begin
        int p, edges, op, a, din;

        // ---------------- directed vector table ----------------
        p = rom.size();   // straight-line: 5 + 7 = 12
        rom.push_back(enc(7,5)); rom.push_back(enc(3,3)); rom.push_back(enc(7,7));
        rom.push_back(enc(0,3)); rom.push_back(enc(9,0)); rom.push_back(enc(15,0));
        tbl[0] = '{p, rom.size()-p, 0, 12, 0, 0, 6, 12, 1, 12};
        p = rom.size();   // 0 - 1 wraps to 255 with borrow
        rom.push_back(enc(7,0)); rom.push_back(enc(3,0)); rom.push_back(enc(7,1));
        rom.push_back(enc(3,1)); rom.push_back(enc(7,0)); rom.push_back(enc(1,1));
        rom.push_back(enc(15,0));
        tbl[1] = '{p, rom.size()-p, 0, 255, 0, 1, 7, 14, 0, 12};
        p = rom.size();   // 255 + 1 -> 0 with carry
        rom.push_back(enc(0,1)); rom.push_back(enc(15,0));
        tbl[2] = '{p, rom.size()-p, 0, 0, 1, 1, 2, 4, 0, 12};
        p = rom.size();   // AND keeps C
        rom.push_back(enc(4,0)); rom.push_back(enc(15,0));
        tbl[3] = '{p, rom.size()-p, 0, 0, 1, 1, 2, 4, 0, 12};
        p = rom.size();   // countdown loop
        rom.push_back(enc(7,3)); rom.push_back(enc(3,2)); rom.push_back(enc(7,1));
        rom.push_back(enc(3,1)); rom.push_back(enc(2,2)); rom.push_back(enc(1,1));
        rom.push_back(enc(3,2)); rom.push_back(enc(11,9)); rom.push_back(enc(10,4));
        rom.push_back(enc(15,0));
        tbl[4] = '{p, rom.size()-p, 0, BR_EN ? 0 : 2, BR_EN ? 1 : 0, 0, 10, BR_EN ? 38 : 20, 0, 12};
        p = rom.size();   // read back M[2]
        rom.push_back(enc(2,2)); rom.push_back(enc(9,0)); rom.push_back(enc(15,0));
        tbl[5] = '{p, rom.size()-p, 0, BR_EN ? 0 : 2, BR_EN ? 1 : 0, 0, 3, 6, 1, BR_EN ? 0 : 2};
        p = rom.size();   // IN 0xA5 ^ M[3]=5 -> 0xA0
        rom.push_back(enc(8,0)); rom.push_back(enc(6,3)); rom.push_back(enc(9,0));
        rom.push_back(enc(15,0));
        tbl[6] = '{p, rom.size()-p, 165, 160, 0, 0, 4, 8, 1, 160};
        p = rom.size();   // 17 - 31 -> 242 with borrow
        rom.push_back(enc(7,31)); rom.push_back(enc(3,7)); rom.push_back(enc(7,17));
        rom.push_back(enc(1,7)); rom.push_back(enc(15,0));
        tbl[7] = '{p, rom.size()-p, 0, 242, 0, 1, 5, 10, 0, 160};
        p = rom.size();   // JC with C=1
        rom.push_back(enc(12,3)); rom.push_back(enc(7,1)); rom.push_back(enc(15,0));
        rom.push_back(enc(7,2));  rom.push_back(enc(15,0));
        tbl[8] = '{p, rom.size()-p, 0, BR_EN ? 2 : 1, 0, 1, BR_EN ? 5 : 3, 6, 0, 160};

        // ---------------- reset ----------------
        reset_n = 1'b0; start = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0; data_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_reset_state("reset");
        repeat (4) @(negedge clk);
        check_reset_state("idle");

        // ---------------- directed table ----------------
        for (int i = 0; i < 9; i++) begin
            load_prog(tbl[i].p0, tbl[i].len);
            run_dut(tbl[i].din, edges);
            model_run(tbl[i].din);
            chk($sformatf("vec%0d_acc", i),    int'(acc_out),    tbl[i].acc);
            chk($sformatf("vec%0d_z", i),      int'(zero_flag),  tbl[i].z);
            chk($sformatf("vec%0d_c", i),      int'(carry_flag), tbl[i].c);
            chk($sformatf("vec%0d_pc", i),     int'(pc_out),     tbl[i].pc);
            chk($sformatf("vec%0d_cycles", i), edges,            tbl[i].cyc);
            chk($sformatf("vec%0d_nout", i),   dut_outs.size(),  tbl[i].nout);
            chk($sformatf("vec%0d_odata", i),  int'(out_data),   tbl[i].odata);
        end

        // ---------------- pc wrap with ignored strobes ----------------
        p = rom.size();
        for (int i = 0; i < DEPTH; i++) rom.push_back(enc(13,0));
        load_prog(p, DEPTH);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int j = 0; j < 80; j++) begin
            chk($sformatf("wrap_pc_e%0d", j), int'(pc_out), ((j + 1) / 2) % DEPTH);
            if (j == 20) begin
                prog_we = 1'b1; prog_addr = AW'(15); prog_data = enc(15,0);
            end else if (j == 21) begin
                prog_we = 1'b0;
            end
            if (j == 40) start = 1'b1;
            else if (j == 41) start = 1'b0;
            @(negedge clk);
        end
        chk("wrap_still_running", int'(halted), 0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        check_reset_state("wrap_reset");

        // ---------------- define every data RAM word ----------------
        p = rom.size();
        rom.push_back(enc(7,21));
        for (int i = 0; i < DEPTH - 2; i++) rom.push_back(enc(3,i));
        rom.push_back(enc(15,0));
        load_prog(p, DEPTH);
        run_vs_model("initA", 0);
        p = rom.size();
        rom.push_back(enc(7,9)); rom.push_back(enc(3,30)); rom.push_back(enc(3,31));
        rom.push_back(enc(15,0));
        load_prog(p, 4);
        run_vs_model("initB", 0);

        // ---------------- reset just before STORE 4 executes ----------------
        p = rom.size();
        rom.push_back(enc(7,9)); rom.push_back(enc(3,4)); rom.push_back(enc(15,0));
        load_prog(p, 3);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #4 reset_n = 1'b0;
        @(negedge clk);
        check_reset_state("midop_reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        p = rom.size();
        rom.push_back(enc(2,4)); rom.push_back(enc(15,0));
        load_prog(p, 2);
        run_vs_model("midop_load", 0);
        chk("midop_m4_kept", int'(acc_out), 21);

        // ---------------- random forward-branching programs ----------------
        for (int r = 0; r < 24; r++) begin
            p = rom.size();
            for (int i = 0; i < DEPTH - 1; i++) begin
                op = int'($urandom_range(0, 15));
                if (op == 15 && $urandom_range(0, 3) != 0) op = 13;
                if (op >= 10 && op <= 12) a = int'($urandom_range(i + 1, DEPTH - 1));
                else                      a = int'($urandom_range(0, DEPTH - 1));
                rom.push_back(enc(op, a));
            end
            rom.push_back(enc(15,0));
            load_prog(p, DEPTH);
            din = int'($urandom_range(0, MASK));
            run_vs_model($sformatf("rnd%0d", r), din);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
